pc_sequencer: RTL

Registered program-counter unit for the WISC-15 fetch stage; the parametrised successor to the combinational next-PC logic. It holds the PC and evaluates conditional branches, calls and returns. A hardware return-address stack (RAS) makes `ret` independent of the register file, with `ret_reg` as the fallback source. It sits between decode (control and immediates) and instruction memory (`pc`).

---
 rtl/pc_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered fetch PC with conditional branch, call/return and return-address stack
module pc_sequencer #(
  parameter int              PC_W      = 16,
  parameter int              RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           branch,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           halt,
  input  logic [2:0]                     cond,
  input  logic                           z,
  input  logic                           v,
  input  logic                           n,
  input  logic [PC_W-1:0]                b_imm,
  input  logic [PC_W-1:0]                c_imm,
  input  logic [PC_W-1:0]                ret_reg,
  output logic [PC_W-1:0]                pc,
  output logic [PC_W-1:0]                next_pc,
  output logic                           halted,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state;
  logic [PC_W-1:0]   ras [RAS_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     top_idx;
  logic [PC_W-1:0]   seq;
  logic              cond_ok;
  logic              accept;
  logic              ras_full;
  logic              ras_empty;
  logic              do_push;
  logic              do_pop;
  logic              underflow_evt;
  logic              halt_evt;

  assign seq       = pc + PC_W'(1);
  assign accept    = (state == RUN) && !stall;
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);
  // wr_ptr names the next free slot; the live top sits one below it
  assign top_idx   = wr_ptr - AW'(1);

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      3'b000: cond_ok = !z;
      3'b001: cond_ok = z;
      3'b010: cond_ok = !z && !n;
      3'b011: cond_ok = n;
      3'b100: cond_ok = !n;
      3'b101: cond_ok = n || z;
      3'b110: cond_ok = v;
      default: cond_ok = 1'b1;
    endcase
  end

  always_comb begin
    next_pc       = pc;
    do_push       = 1'b0;
    do_pop        = 1'b0;
    underflow_evt = 1'b0;
    halt_evt      = 1'b0;
    if (accept) begin
      if (branch) begin
        next_pc = cond_ok ? (seq + b_imm) : seq;
      end else if (call) begin
        next_pc = seq + c_imm;
        do_push = 1'b1;
      end else if (ret) begin
        if (!ras_empty) begin
          next_pc = ras[top_idx];
          do_pop  = 1'b1;
        end else begin
          next_pc       = ret_reg;
          underflow_evt = 1'b1;
        end
      end else if (halt) begin
        next_pc  = pc;
        halt_evt = 1'b1;
      end else begin
        next_pc = seq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      pc            <= RESET_PC;
      halted        <= 1'b0;
      ras_count     <= '0;
      wr_ptr        <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= next_pc;
      ras_overflow  <= do_push && ras_full;
      ras_underflow <= underflow_evt;
      if (halt_evt) begin
        state  <= HALTED;
        halted <= 1'b1;
      end
      // A push into a full stack lands on the oldest slot, so the count saturates
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (!ras_full) ras_count <= ras_count + CW'(1);
      end else if (do_pop) begin
        wr_ptr    <= wr_ptr - AW'(1);
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) ras[wr_ptr] <= seq;
  end

endmodule
